// File: rtl/dispatch_pkg.sv
// dispatch_pkg
// Shared definitions for the dual-core dispatcher: instruction field
// positions, the hazard key width, the core identifier type and small
// helpers that extract the source/destination keys and test two
// instructions for a data hazard.
package dispatch_pkg;

   localparam int INSTR_W  = 32;
   localparam int PIN_BIT  = 27;
   localparam int PCORE_BIT = 26;
   localparam int SSP_BIT  = 23;
   localparam int DSP_BIT  = 22;
   localparam int DADDR_HI = 21;
   localparam int DADDR_LO = 11;
   localparam int SADDR_HI = 10;
   localparam int SADDR_LO = 0;
   localparam int KEY_W    = 12;

   typedef enum logic {
      CORE0 = 1'b0,
      CORE1 = 1'b1
   } core_id_t;

   // Source key is the source space bit joined with the source address.
   function automatic logic [KEY_W-1:0] srcKey(input logic [INSTR_W-1:0] instr);
      return {instr[SSP_BIT], instr[SADDR_HI:SADDR_LO]};
   endfunction

   // Destination key is the destination space bit joined with the destination address.
   function automatic logic [KEY_W-1:0] dstKey(input logic [INSTR_W-1:0] instr);
      return {instr[DSP_BIT], instr[DADDR_HI:DADDR_LO]};
   endfunction

   // A new instruction conflicts with a queued one on RAW, WAR or WAW
   // overlap of their keys.
   function automatic logic keysConflict(input logic [INSTR_W-1:0] newInstr,
                                         input logic [INSTR_W-1:0] entryInstr);
      return (srcKey(newInstr) == dstKey(entryInstr)) ||
             (dstKey(newInstr) == srcKey(entryInstr)) ||
             (dstKey(newInstr) == dstKey(entryInstr));
   endfunction

endpackage

// File: rtl/dispatch_queue.sv
// dispatch_queue
// Circular-buffer FIFO holding instructions waiting for one core.
// Ports:
//   clk, resetn      clock and synchronous active-low reset
//   i_push, i_pushData  write request and data (ignored when full)
//   i_pop            pop request (ignored when empty)
//   o_headData       oldest entry
//   o_full, o_empty  occupancy flags
//   o_count          occupancy, 0..DEPTH
//   o_slotValid      per-slot occupied flags, for hazard comparison
//   o_entries        all storage slots flattened, slot g at [g*32 +: 32]
module dispatch_queue
   import dispatch_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       i_push,
   input  logic [INSTR_W-1:0]         i_pushData,
   input  logic                       i_pop,
   output logic [INSTR_W-1:0]         o_headData,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic [DEPTH-1:0]           o_slotValid,
   output logic [DEPTH*INSTR_W-1:0]   o_entries
);

   localparam int AW = $clog2(DEPTH);

   logic [INSTR_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_rdPtr;
   logic [AW-1:0]      r_wrPtr;
   logic [AW:0]        r_count;
   logic               w_doPush;
   logic               w_doPop;

   assign o_full     = (r_count == (AW+1)'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_headData = r_mem[r_rdPtr];
   assign w_doPush   = i_push && !o_full;
   assign w_doPop    = i_pop && !o_empty;

   // A slot is occupied when its distance from the read pointer, taken
   // modulo DEPTH, is below the current count.
   for (genvar g = 0; g < DEPTH; g++) begin : gSlot
      logic [AW-1:0] w_offset;
      assign w_offset                    = AW'(g) - r_rdPtr;
      assign o_slotValid[g]              = ({1'b0, w_offset} < r_count);
      assign o_entries[g*INSTR_W +: INSTR_W] = r_mem[g];
   end

   // Storage, pointers and count; pointers wrap naturally because DEPTH
   // is a power of two. Reset clears storage so the head reads zero.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
            r_wrPtr        <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dual_core_dispatcher.sv
// dual_core_dispatcher
// Steers each fetched instruction into one of two per-core queues.
// Pinned instructions go to the core they name; unpinned ones follow a
// data hazard to the queue holding the conflicting entry, stall when both
// queues conflict, and otherwise alternate via pref_core.
// Ports:
//   clk, resetn                 clock and synchronous active-low reset
//   in_valid/in_instr/in_ready  fetch-side handshake
//   cN_valid/cN_instr/cN_ready  core-side handshake, one per core
//   cN_count                    queue occupancy
//   pref_core                   target for the next unpinned, hazard-free instruction
module dual_core_dispatcher
   import dispatch_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   in_valid,
   input  logic [31:0]            in_instr,
   output logic                   in_ready,
   output logic                   c0_valid,
   output logic [31:0]            c0_instr,
   input  logic                   c0_ready,
   output logic [$clog2(DEPTH):0] c0_count,
   output logic                   c1_valid,
   output logic [31:0]            c1_instr,
   input  logic                   c1_ready,
   output logic [$clog2(DEPTH):0] c1_count,
   output logic                   pref_core
);

   core_id_t                   r_prefCore;
   core_id_t                   w_target;
   logic                       w_stall;
   logic                       w_hazard0;
   logic                       w_hazard1;
   logic                       w_full0;
   logic                       w_full1;
   logic                       w_empty0;
   logic                       w_empty1;
   logic                       w_transfer;
   logic                       w_push0;
   logic                       w_push1;
   logic [DEPTH-1:0]           w_slotValid0;
   logic [DEPTH-1:0]           w_slotValid1;
   logic [DEPTH*INSTR_W-1:0]   w_entries0;
   logic [DEPTH*INSTR_W-1:0]   w_entries1;

   // Compare the incoming instruction against every occupied slot of each
   // queue. An entry being popped this cycle is still occupied here.
   always_comb begin
      w_hazard0 = 1'b0;
      w_hazard1 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_slotValid0[i] && keysConflict(in_instr, w_entries0[i*INSTR_W +: INSTR_W])) begin
            w_hazard0 = 1'b1;
         end
         if (w_slotValid1[i] && keysConflict(in_instr, w_entries1[i*INSTR_W +: INSTR_W])) begin
            w_hazard1 = 1'b1;
         end
      end
   end

   // Target resolution: pinning overrides hazards, a hazard in both queues
   // stalls, a single hazard follows its queue, else use the preference.
   always_comb begin
      w_stall  = 1'b0;
      w_target = r_prefCore;
      if (in_instr[PIN_BIT]) begin
         w_target = core_id_t'(in_instr[PCORE_BIT]);
      end else if (w_hazard0 && w_hazard1) begin
         w_stall = 1'b1;
      end else if (w_hazard0) begin
         w_target = CORE0;
      end else if (w_hazard1) begin
         w_target = CORE1;
      end
   end

   // Ready uses only the current full flag, never the core's pop request,
   // so there is no combinational path from cN_ready to in_ready.
   assign in_ready   = !w_stall && ((w_target == CORE1) ? !w_full1 : !w_full0);
   assign w_transfer = in_valid && in_ready;
   assign w_push0    = w_transfer && (w_target == CORE0);
   assign w_push1    = w_transfer && (w_target == CORE1);

   // The preference flips away from whichever core just received an instruction.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_prefCore <= CORE0;
      end else if (w_transfer) begin
         r_prefCore <= core_id_t'(~w_target);
      end
   end

   assign pref_core = r_prefCore;
   assign c0_valid  = !w_empty0;
   assign c1_valid  = !w_empty1;

   dispatch_queue #(.DEPTH(DEPTH)) uQueue0 (
      .clk         (clk),
      .resetn      (resetn),
      .i_push      (w_push0),
      .i_pushData  (in_instr),
      .i_pop       (c0_ready),
      .o_headData  (c0_instr),
      .o_full      (w_full0),
      .o_empty     (w_empty0),
      .o_count     (c0_count),
      .o_slotValid (w_slotValid0),
      .o_entries   (w_entries0)
   );

   dispatch_queue #(.DEPTH(DEPTH)) uQueue1 (
      .clk         (clk),
      .resetn      (resetn),
      .i_push      (w_push1),
      .i_pushData  (in_instr),
      .i_pop       (c1_ready),
      .o_headData  (c1_instr),
      .o_full      (w_full1),
      .o_empty     (w_empty1),
      .o_count     (c1_count),
      .o_slotValid (w_slotValid1),
      .o_entries   (w_entries1)
   );

endmodule
